// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg -- shared constants and types for the register-file
// write-back arbiter.
//   DEF_NREQ / DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default parameter values
//   wb_req_t  : one write-back request (addr, data) at the default widths
//   REG_ZERO  : index of the hard-wired zero register
package regfile_arb_pkg;

  localparam int DEF_NREQ       = 2;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin arbiter.
//   req [N]      : request vector
//   ptr [PW]     : index of the last granted requester
//   gnt [N]      : one-hot grant (zero when no request)
// The search starts at ptr+1 (mod N), so the last winner has lowest priority.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter -- round-robin scheduler for the register file's single
// write port, with a registered write port and an optional pending-write
// scoreboard.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready [NREQ]     : per-producer handshake (ready = grant)
//   req_addr/req_data              : packed per-producer index and data
//   rf_wen/rf_waddr/rf_wdata       : registered register-file write port
//   alloc_valid/alloc_addr         : issue stage marks a destination pending
//   busy [2**ADDR_WIDTH]           : registered pending-write bitmap
// Build option: define REGFILE_WB_ARB_SCOREBOARD_EN to implement the
// scoreboard; otherwise busy is tied to zero and alloc_* are ignored.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic                       alloc_valid,
  input  logic [ADDR_WIDTH-1:0]      alloc_addr,
  output logic [(1<<ADDR_WIDTH)-1:0] busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  // Same layout as wb_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_entry_t;

  req_entry_t          reqs [NREQ];
  logic [PW-1:0]       ptr_reg;
  logic [PW-1:0]       win_idx;
  req_entry_t          win;
  logic                xfer;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign reqs[gi].addr = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign reqs[gi].data = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (ptr_reg),
    .gnt (req_ready)
  );

  // No output back-pressure: any valid request produces a transfer.
  assign xfer = |(req_valid & req_ready);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) win_idx = PW'(i);
    end
  end

  assign win = reqs[win_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg  <= PW'(NREQ - 1);
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= 1'b0;
      if (xfer) begin
        ptr_reg  <= win_idx;
        rf_waddr <= win.addr;
        rf_wdata <= win.data;
        // x0 writes complete the handshake but never reach the register file.
        rf_wen   <= (win.addr != ZERO_ADDR);
      end
    end
  end

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
  logic [(1<<ADDR_WIDTH)-1:0] busy_reg;
  logic [(1<<ADDR_WIDTH)-1:0] busy_next;

  always_comb begin
    busy_next = busy_reg;
    if (xfer) busy_next[win.addr] = 1'b0;
    // Set after clear: a same-cycle allocation means a newer producer owns it.
    if (alloc_valid && (alloc_addr != ZERO_ADDR)) busy_next[alloc_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign busy = busy_reg;
`else
  logic unused_alloc;
  assign unused_alloc = ^{alloc_valid, alloc_addr};
  assign busy = '0;
`endif

endmodule
